// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock stability,
// gates the miner-core reset and keeps saturating health counters.
// Runs entirely on the board reference clock.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             force_relock,
    input  logic             clear_status,
    output logic             pll_resetb,
    output logic             core_reset_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                      MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CTR_W   = $clog2(CNT_MAX + 1);

    localparam logic [CTR_W-1:0] RST_LAST     = CTR_W'(PLL_RST_CYCLES - 1);
    localparam logic [CTR_W-1:0] STABLE_LAST  = CTR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic             lock_meta_q, lock_s_q;

    logic             loss_evt, relock_evt, timeout_evt;

    logic             pll_resetb_q, pll_resetb_d;
    logic             core_reset_n_q, core_reset_n_d;
    logic             ready_q, ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] relock_count_q, relock_count_d;
    logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

    // State register, phase counter and two-flop lock synchronizer
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state and phase-counter logic; also flags status events
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_evt    = 1'b0;
        relock_evt  = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_PLL_RST;
                    cnt_d       = '0;
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss takes priority so a coincident force counts once
                if (!lock_s_q) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    loss_evt   = 1'b1;
                    relock_evt = 1'b1;
                end else if (force_relock) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    relock_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values: control outputs follow the next state, status
    // updates saturate and are overridden by a clear
    always_comb begin
        pll_resetb_d    = (state_d != ST_PLL_RST);
        core_reset_n_d  = (state_d == ST_RUN);
        ready_d         = (state_d == ST_RUN);
        lock_lost_d     = lock_lost_q | loss_evt;
        relock_count_d  = relock_count_q;
        timeout_count_d = timeout_count_q;
        if (relock_evt && (relock_count_q != '1)) begin
            relock_count_d = relock_count_q + 1'b1;
        end
        if (timeout_evt && (timeout_count_q != '1)) begin
            timeout_count_d = timeout_count_q + 1'b1;
        end
        if (clear_status) begin
            lock_lost_d     = 1'b0;
            relock_count_d  = '0;
            timeout_count_d = '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pll_resetb_q    <= 1'b0;
            core_reset_n_q  <= 1'b0;
            ready_q         <= 1'b0;
            lock_lost_q     <= 1'b0;
            relock_count_q  <= '0;
            timeout_count_q <= '0;
        end else begin
            pll_resetb_q    <= pll_resetb_d;
            core_reset_n_q  <= core_reset_n_d;
            ready_q         <= ready_d;
            lock_lost_q     <= lock_lost_d;
            relock_count_q  <= relock_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign pll_resetb    = pll_resetb_q;
    assign core_reset_n  = core_reset_n_q;
    assign ready         = ready_q;
    assign lock_lost     = lock_lost_q;
    assign relock_count  = relock_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus randomized
// lock/force/clear traffic, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    localparam int unsigned P_RST    = 4;
    localparam int unsigned P_STABLE = 8;
    localparam int unsigned P_TO     = 32;
    localparam int unsigned P_W      = 4;
    localparam int unsigned SAT      = (1 << P_W) - 1;

    logic           clock_in     = 1'b0;
    logic           reset_n      = 1'b0;
    logic           pll_locked   = 1'b0;
    logic           force_relock = 1'b0;
    logic           clear_status = 1'b0;
    logic           pll_resetb;
    logic           core_reset_n;
    logic           ready;
    logic           lock_lost;
    logic [P_W-1:0] relock_count;
    logic [P_W-1:0] timeout_count;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .CNT_W               (P_W)
    ) dut (
        .clock_in      (clock_in),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .clear_status  (clear_status),
        .pll_resetb    (pll_resetb),
        .core_reset_n  (core_reset_n),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .relock_count  (relock_count),
        .timeout_count (timeout_count)
    );

    always #5 clock_in = ~clock_in;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases of the sequence; elapsed counts edges spent in the phase.
    typedef enum int {PH_RESET, PH_WAIT, PH_STAB, PH_RUN} phase_e;
    phase_e m_phase   = PH_RESET;
    int     m_elapsed = 0;
    bit     m_h0 = 1'b0, m_h1 = 1'b0;   // pll_locked seen 1 and 2 edges ago
    bit     m_lost = 1'b0;
    int     m_relock = 0;
    int     m_timeout = 0;

    function automatic int sat_inc(input int x);
        return (x >= int'(SAT)) ? int'(SAT) : x + 1;
    endfunction

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            m_phase   <= PH_RESET;
            m_elapsed <= 0;
            m_h0      <= 1'b0;
            m_h1      <= 1'b0;
            m_lost    <= 1'b0;
            m_relock  <= 0;
            m_timeout <= 0;
        end else begin
            bit     seen;
            phase_e np;
            int     ne;
            bit     ev_loss, ev_relock, ev_to;
            seen = m_h1;
            np = m_phase; ne = m_elapsed + 1;
            ev_loss = 0; ev_relock = 0; ev_to = 0;
            case (m_phase)
                PH_RESET: if (ne == int'(P_RST)) begin np = PH_WAIT; ne = 0; end
                PH_WAIT: begin
                    if (seen) begin np = PH_STAB; ne = 0; end
                    else if (ne == int'(P_TO)) begin np = PH_RESET; ne = 0; ev_to = 1; end
                end
                PH_STAB: begin
                    if (!seen) begin np = PH_WAIT; ne = 0; end
                    else if (ne == int'(P_STABLE)) begin np = PH_RUN; ne = 0; end
                end
                default: begin
                    if (!seen) begin np = PH_RESET; ne = 0; ev_loss = 1; ev_relock = 1; end
                    else if (force_relock) begin np = PH_RESET; ne = 0; ev_relock = 1; end
                end
            endcase
            m_phase   <= np;
            m_elapsed <= ne;
            m_h1      <= m_h0;
            m_h0      <= pll_locked;
            if (clear_status) begin
                m_lost <= 0; m_relock <= 0; m_timeout <= 0;
            end else begin
                if (ev_loss)   m_lost    <= 1;
                if (ev_relock) m_relock  <= sat_inc(m_relock);
                if (ev_to)     m_timeout <= sat_inc(m_timeout);
            end
        end
    end

    // Continuous comparison of every output against the model, off-edge
    always @(negedge clock_in) begin
        check("m_pll_resetb", 32'(pll_resetb), 32'(m_phase != PH_RESET));
        check("m_core_reset_n", 32'(core_reset_n), 32'(m_phase == PH_RUN));
        check("m_ready", 32'(ready), 32'(m_phase == PH_RUN));
        check("m_lock_lost", 32'(lock_lost), 32'(m_lost));
        check("m_relock_count", 32'(relock_count), 32'(m_relock));
        check("m_timeout_count", 32'(timeout_count), 32'(m_timeout));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    // Ticks until the chosen output reaches val (0:pll_resetb, 1:core_reset_n)
    task automatic ticks_to(input int sel, input logic val, input int budget, output int n);
        logic cur;
        n = 0;
        do begin
            tick();
            n++;
            cur = (sel == 0) ? pll_resetb : core_reset_n;
        end while (cur !== val && n < budget);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_reached_run"}, 32'(ready), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n;
        int low_left;

        // Reset values
        tick();
        check("rst_pll_resetb", 32'(pll_resetb), 32'd0);
        check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_counters", 32'({lock_lost, relock_count, timeout_count}), 32'd0);

        // Power-up nominal
        reset_n = 1'b1;
        ticks_to(0, 1'b1, 20, n);
        check("nom_pll_rst_len", 32'(n), 32'(P_RST));
        repeat (10) tick();
        check("nom_no_early_run", 32'(ready), 32'd0);
        pll_locked = 1'b1;
        ticks_to(1, 1'b1, 40, n);
        check("nom_release_edges", 32'(n), 32'(P_STABLE + 3));
        check("nom_ready", 32'(ready), 32'd1);
        check("nom_counters", 32'({lock_lost, relock_count, timeout_count}), 32'd0);

        // Glitchy lock: 5 high, 1 low, then steady
        pll_locked = 1'b0;
        apply_reset();
        ticks_to(0, 1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        ticks_to(1, 1'b1, 40, n);
        check("glitch_release_edges", 32'(n), 32'(P_STABLE + 3));
        check("glitch_relock", 32'(relock_count), 32'd0);
        check("glitch_lock_lost", 32'(lock_lost), 32'd0);

        // Timeout with lock held low; saturation after 15
        pll_locked = 1'b0;
        apply_reset();
        ticks_to(0, 1'b1, 20, n);
        for (int i = 1; i <= 16; i++) begin
            ticks_to(0, 1'b0, 40, n);
            check("to_wait_len", 32'(n), 32'(P_TO));
            check("to_count", 32'(timeout_count), 32'((i > int'(SAT)) ? int'(SAT) : i));
            ticks_to(0, 1'b1, 20, n);
            check("to_pulse_len", 32'(n), 32'(P_RST));
        end

        // Lock loss in RUN
        pll_locked = 1'b1;
        wait_ready("loss_pre", 200);
        pulse_clear();
        check("clr_all", 32'({lock_lost, relock_count, timeout_count}), 32'd0);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("loss_still_run", 32'(core_reset_n), 32'd1);
        tick();
        check("loss_core_reset_n", 32'(core_reset_n), 32'd0);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_pll_resetb", 32'(pll_resetb), 32'd0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        check("loss_relock", 32'(relock_count), 32'd1);
        wait_ready("loss_rerelease", 200);

        // Force relock alone
        pulse_clear();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check("force_relock", 32'(relock_count), 32'd1);
        check("force_lock_lost", 32'(lock_lost), 32'd0);
        check("force_pll_resetb", 32'(pll_resetb), 32'd0);
        wait_ready("force_rerelease", 200);

        // Force coincident with lock loss counts once
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check("both_relock", 32'(relock_count), 32'd2);
        check("both_lock_lost", 32'(lock_lost), 32'd1);
        wait_ready("both_rerelease", 200);

        // Clear in the same cycle as an increment
        force_relock = 1'b1;
        clear_status = 1'b1;
        tick();
        force_relock = 1'b0;
        clear_status = 1'b0;
        check("clrwin_status", 32'({lock_lost, relock_count, timeout_count}), 32'd0);
        check("clrwin_core_reset_n", 32'(core_reset_n), 32'd0);
        wait_ready("clrwin_rerelease", 200);

        // Randomized traffic
        low_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (low_left > 0) begin
                pll_locked = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                pll_locked = 1'b0;
                low_left = int'($urandom_range(0, 45));
            end else begin
                pll_locked = 1'b1;
            end
            force_relock = ($urandom_range(0, 24) == 0);
            clear_status = ($urandom_range(0, 69) == 0);
            tick();
        end
        force_relock = 1'b0;
        clear_status = 1'b0;

        // Async reset mid-RUN
        pll_locked = 1'b1;
        wait_ready("async_pre", 300);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        wait_ready("async_pre2", 200);
        @(posedge clock_in);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_core_reset_n", 32'(core_reset_n), 32'd0);
        check("async_pll_resetb", 32'(pll_resetb), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_counters", 32'({lock_lost, relock_count, timeout_count}), 32'd0);
        tick();
        reset_n = 1'b1;
        ticks_to(0, 1'b1, 20, n);
        check("async_restart_len", 32'(n), 32'(P_RST));
        wait_ready("async_rerelease", 200);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
